uart_rx_frame: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 16x receiver.
- Configurable oversample ratio, data width, parity mode and stop-bit count.
- Adds input synchronisation, false-start rejection, parity and framing error detection, and a valid/ready output handshake with overrun reporting.
- Sits between the board RX pin and the command/FIFO logic on the system clock.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_bit_timer.sv | 61 ++++++
 rtl/uart_rx_frame.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Optional build macro used by the receiver: UART_RX_MAJORITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Widest supported data word.
  localparam int MAX_DATA_BITS = 9;

  // Expected parity bit for a data word. Unused upper bits must be zero.
  function automatic logic par_calc(input logic [MAX_DATA_BITS-1:0] bits, input int mode);
    case (mode)
      PARITY_EVEN: return ^bits;
      PARITY_ODD:  return ~^bits;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter and sample strobe for the UART receiver.
// With UART_RX_MAJORITY_EN defined, each sample is a 2-of-3 vote over
// cnt = mid-1, mid, mid+1 and the strobe fires at mid+1; otherwise a single
// sample is taken at mid.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic rx_s,
  output logic sample_en,
  output logic sample_val
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int MID   = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);

  logic [CNT_W-1:0] cnt;

  // Free-running bit-period counter; held at zero while the receiver is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_POST = CNT_W'(MID + 1);

  logic s_pre;
  logic s_mid;

  // Capture the two early votes; the third is rx_s live at mid+1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_pre <= 1'b1;
      s_mid <= 1'b1;
    end else if (enable) begin
      if (cnt == CNT_PRE) s_pre <= rx_s;
      if (cnt == CNT_MID) s_mid <= rx_s;
    end
  end

  assign sample_en  = enable && (cnt == CNT_POST);
  assign sample_val = (s_pre & s_mid) | (s_pre & rx_s) | (s_mid & rx_s);
`else
  assign sample_en  = enable && (cnt == CNT_MID);
  assign sample_val = rx_s;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: synchroniser, false-start rejection, optional
// parity, 1 or 2 stop bits, framing/parity flags and a valid/ready output
// with overrun reporting.
// Optional build macro: UART_RX_MAJORITY_EN (3-sample majority vote per bit).
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

`ifdef UART_RX_MAJORITY_EN
  localparam int MIN_CPB = 8;
`else
  localparam int MIN_CPB = 4;
`endif

  if (CLKS_PER_BIT < MIN_CPB) begin : g_bad_cpb
    $error("uart_rx_frame: CLKS_PER_BIT %0d below minimum %0d", CLKS_PER_BIT, MIN_CPB);
  end
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_rx_frame: DATA_BITS %0d outside 5..9", DATA_BITS);
  end
  if (PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD) begin : g_bad_parity
    $error("uart_rx_frame: PARITY_MODE %0d is not 0, 1 or 2", PARITY_MODE);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_frame: STOP_BITS %0d is not 1 or 2", STOP_BITS);
  end

  localparam int IDX_W = $clog2(MAX_DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);

  rx_state_t            state;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_pend;
  logic                 ferr_pend;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 sample_en;
  logic                 sample_val;

  // Two-flop synchroniser for the asynchronous line.
  // NOTE: these flops reset to the idle-high level so leaving reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == IDLE),
    .enable    (state != IDLE),
    .rx_s      (rx_s),
    .sample_en (sample_en),
    .sample_val(sample_val)
  );

  // Frame FSM, shift register and registered output handshake.
  // NOTE: non-blocking assignments throughout, so every read sees the pre-edge value
  // and later assignments in the block (frame load) cleanly override earlier defaults (accept).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      shreg      <= '0;
      perr_pend  <= 1'b0;
      ferr_pend  <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (valid && ready) valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) state <= START;
        end

        START: begin
          if (sample_en) begin
            if (sample_val) begin
              state <= IDLE;
            end else begin
              state     <= DATA;
              idx       <= '0;
              perr_pend <= 1'b0;
              ferr_pend <= 1'b0;
            end
          end
        end

        DATA: begin
          if (sample_en) begin
            shreg <= {sample_val, shreg[DATA_BITS-1:1]};
            if (idx == IDX_LAST_DATA) begin
              idx   <= '0;
              state <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        PARITY: begin
          if (sample_en) begin
            perr_pend <= (sample_val != par_calc(MAX_DATA_BITS'(shreg), PARITY_MODE));
            state     <= STOP;
          end
        end

        STOP: begin
          if (sample_en) begin
            if (idx == IDX_LAST_STOP) begin
              idx   <= '0;
              state <= (ferr_pend || !sample_val) ? WAIT_IDLE : IDLE;
              if (!valid || ready) begin
                data       <= shreg;
                parity_err <= perr_pend;
                frame_err  <= ferr_pend || !sample_val;
                valid      <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              idx <= idx + IDX_W'(1);
              if (!sample_val) ferr_pend <= 1'b1;
            end
          end
        end

        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: three instances (8N1, 8E1, 8N2),
// a table of frames with hand-computed results, plus hand-written sequences
// for latency, glitch rejection, break handling, overrun and mid-frame reset.
module tb_uart_rx_frame;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rx_w;
  logic [2:0] ready_w;
  logic [2:0] valid_w;
  logic [2:0] perr_w;
  logic [2:0] ferr_w;
  logic [2:0] ovr_w;
  logic [2:0] busy_w;
  logic [7:0] data_w [3];

  // 0: 8N1
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .rx(rx_w[0]), .data(data_w[0]), .valid(valid_w[0]),
    .ready(ready_w[0]), .parity_err(perr_w[0]), .frame_err(ferr_w[0]),
    .overrun(ovr_w[0]), .busy(busy_w[0]));

  // 1: 8E1
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_b (
    .clk(clk), .reset(reset), .rx(rx_w[1]), .data(data_w[1]), .valid(valid_w[1]),
    .ready(ready_w[1]), .parity_err(perr_w[1]), .frame_err(ferr_w[1]),
    .overrun(ovr_w[1]), .busy(busy_w[1]));

  // 2: 8N2
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .reset(reset), .rx(rx_w[2]), .data(data_w[2]), .valid(valid_w[2]),
    .ready(ready_w[2]), .parity_err(perr_w[2]), .frame_err(ferr_w[2]),
    .overrun(ovr_w[2]), .busy(busy_w[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Output monitor: valid rising edges, valid-high cycles, overrun-high cycles.
  int         rise_cnt [3] = '{0, 0, 0};
  int         rise_t   [3] = '{0, 0, 0};
  int         high_cnt [3] = '{0, 0, 0};
  int         ovr_cnt  [3] = '{0, 0, 0};
  logic [7:0] cap_data [3];
  logic       cap_perr [3];
  logic       cap_ferr [3];
  logic [2:0] valid_q = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid_w[i] && !valid_q[i]) begin
        rise_cnt[i] = rise_cnt[i] + 1;
        rise_t[i]   = cyc;
        cap_data[i] = data_w[i];
        cap_perr[i] = perr_w[i];
        cap_ferr[i] = ferr_w[i];
      end
      if (valid_w[i]) high_cnt[i] = high_cnt[i] + 1;
      if (ovr_w[i])   ovr_cnt[i]  = ovr_cnt[i] + 1;
      valid_q[i] = valid_w[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Index of the first posedge that samples the start bit.
  int t_start = 0;

  // Drive one frame on instance sel, starting at the current negedge.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stop_v);
    logic [15:0] bits;
    int n;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin
      bits[n] = d[i]; n++;
    end
    if (sel == 1) begin
      bits[n] = pbit; n++;
    end
    bits[n] = stop_v[0]; n++;
    if (sel == 2) begin
      bits[n] = stop_v[1]; n++;
    end
    t_start = cyc + 1;
    for (int b = 0; b < n; b++) begin
      rx_w[sel] = bits[b];
      repeat (CPB) @(negedge clk);
    end
  endtask

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic       pbit;
    logic [1:0] stop_v;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    int h0;
    int o0;
    int ts;

    // sel, data, parity bit, stop bits {2nd,1st}, expected data, parity_err, frame_err
    vecs[0]  = '{0, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{0, 8'hFF, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0};
    vecs[2]  = '{0, 8'h81, 1'b0, 2'b11, 8'h81, 1'b0, 1'b0};
    vecs[3]  = '{0, 8'h5A, 1'b0, 2'b00, 8'h5A, 1'b0, 1'b1};
    vecs[4]  = '{1, 8'h3C, 1'b1, 2'b11, 8'h3C, 1'b1, 1'b0};
    vecs[5]  = '{1, 8'h3C, 1'b0, 2'b11, 8'h3C, 1'b0, 1'b0};
    vecs[6]  = '{1, 8'h01, 1'b1, 2'b11, 8'h01, 1'b0, 1'b0};
    vecs[7]  = '{1, 8'h01, 1'b0, 2'b11, 8'h01, 1'b1, 1'b0};
    vecs[8]  = '{1, 8'h7F, 1'b1, 2'b11, 8'h7F, 1'b0, 1'b0};
    vecs[9]  = '{1, 8'hE0, 1'b0, 2'b11, 8'hE0, 1'b1, 1'b0};
    vecs[10] = '{2, 8'h96, 1'b0, 2'b11, 8'h96, 1'b0, 1'b0};
    vecs[11] = '{2, 8'h69, 1'b0, 2'b10, 8'h69, 1'b0, 1'b1};

    rx_w    = '1;
    ready_w = '0;

    // Reset state
    idle(3);
    check("reset data",       32'(data_w[0]), 32'h00);
    check("reset valid",      32'(valid_w),   32'h0);
    check("reset parity_err", 32'(perr_w),    32'h0);
    check("reset frame_err",  32'(ferr_w),    32'h0);
    check("reset overrun",    32'(ovr_w),     32'h0);
    check("reset busy",       32'(busy_w),    32'h0);
    reset = 1'b1;
    idle(4);

    // Test 1: 8N1 0xA5 latency and single-cycle valid
    ready_w = '1;
    r0 = rise_cnt[0];
    h0 = high_cnt[0];
    send_frame(0, 8'hA5, 1'b0, 2'b11);
    rx_w[0] = 1'b1;
    idle(2 * CPB);
    check("t1 words",      32'(rise_cnt[0] - r0),     32'd1);
    check("t1 latency",    32'(rise_t[0] - t_start),  32'd155);
    check("t1 data",       32'(cap_data[0]),          32'hA5);
    check("t1 parity_err", 32'(cap_perr[0]),          32'h0);
    check("t1 frame_err",  32'(cap_ferr[0]),          32'h0);
    check("t1 valid cycles", 32'(high_cnt[0] - h0),   32'd1);

    // Table of frames
    for (int v = 0; v < 12; v++) begin
      r0 = rise_cnt[vecs[v].sel];
      send_frame(vecs[v].sel, vecs[v].d, vecs[v].pbit, vecs[v].stop_v);
      rx_w[vecs[v].sel] = 1'b1;
      idle(2 * CPB);
      check($sformatf("vec%0d words", v),      32'(rise_cnt[vecs[v].sel] - r0), 32'd1);
      check($sformatf("vec%0d data", v),       32'(cap_data[vecs[v].sel]),      32'(vecs[v].exp_data));
      check($sformatf("vec%0d parity_err", v), 32'(cap_perr[vecs[v].sel]),      32'(vecs[v].exp_perr));
      check($sformatf("vec%0d frame_err", v),  32'(cap_ferr[vecs[v].sel]),      32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d busy", v),       32'(busy_w[vecs[v].sel]),        32'h0);
    end

    // Test 3: 6-cycle glitch is rejected
    r0 = rise_cnt[0];
    rx_w[0] = 1'b0;
    ts = cyc + 1;
    idle(6);
    rx_w[0] = 1'b1;
    check("t3 busy during glitch", 32'(busy_w[0]), 32'h1);
    idle(5);
    check("t3 busy at cycle 10", 32'(busy_w[0]), 32'h1);
    idle(1);
    check("t3 busy at cycle 11", 32'(busy_w[0]), 32'h0);
    check("t3 cycle index", 32'(cyc - ts), 32'd11);
    idle(2 * CPB);
    check("t3 words", 32'(rise_cnt[0] - r0), 32'd0);

    // Test 4: 8N2, second stop low, then break held low
    r0 = rise_cnt[2];
    send_frame(2, 8'hC3, 1'b0, 2'b01);
    idle(400);
    check("t4 words",     32'(rise_cnt[2] - r0), 32'd1);
    check("t4 data",      32'(cap_data[2]),      32'hC3);
    check("t4 frame_err", 32'(cap_ferr[2]),      32'h1);
    check("t4 busy in break", 32'(busy_w[2]),    32'h1);
    rx_w[2] = 1'b1;
    idle(4);
    check("t4 busy after break", 32'(busy_w[2]), 32'h0);
    check("t4 words after break", 32'(rise_cnt[2] - r0), 32'd1);
    send_frame(2, 8'h3A, 1'b0, 2'b11);
    idle(2 * CPB);
    check("t4 next words",     32'(rise_cnt[2] - r0), 32'd2);
    check("t4 next data",      32'(cap_data[2]),      32'h3A);
    check("t4 next frame_err", 32'(cap_ferr[2]),      32'h0);

    // Test 5: overrun while stalled, then accept in the completion cycle
    ready_w[0] = 1'b0;
    o0 = ovr_cnt[0];
    send_frame(0, 8'h11, 1'b0, 2'b11);
    idle(2 * CPB);
    check("t5 first valid", 32'(valid_w[0]), 32'h1);
    check("t5 first data",  32'(data_w[0]),  32'h11);
    send_frame(0, 8'h22, 1'b0, 2'b11);
    idle(2 * CPB);
    check("t5 kept data",      32'(data_w[0]),       32'h11);
    check("t5 kept valid",     32'(valid_w[0]),      32'h1);
    check("t5 overrun pulses", 32'(ovr_cnt[0] - o0), 32'd1);
    r0 = rise_cnt[0];
    ts = cyc + 1;
    fork
      send_frame(0, 8'h33, 1'b0, 2'b11);
      begin
        repeat (155) @(negedge clk);
        ready_w[0] = 1'b1;
        check("t5 before load data",  32'(data_w[0]),  32'h11);
        check("t5 before load valid", 32'(valid_w[0]), 32'h1);
        @(negedge clk);
        ready_w[0] = 1'b0;
        check("t5 load valid",   32'(valid_w[0]), 32'h1);
        check("t5 load data",    32'(data_w[0]),  32'h33);
        check("t5 load overrun", 32'(ovr_w[0]),   32'h0);
        check("t5 load cycle",   32'(cyc - ts),   32'd155);
      end
    join
    idle(2 * CPB);
    check("t5 no new overrun",  32'(ovr_cnt[0] - o0),  32'd1);
    check("t5 valid unbroken",  32'(rise_cnt[0] - r0), 32'd0);
    check("t5 held data",       32'(data_w[0]),        32'h33);

    // Test 6: asynchronous reset in data bit 4
    fork
      send_frame(0, 8'hC6, 1'b0, 2'b11);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        check("t6 busy before reset",  32'(busy_w[0]),  32'h1);
        check("t6 valid before reset", 32'(valid_w[0]), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("t6 reset data",       32'(data_w[0]),  32'h00);
        check("t6 reset valid",      32'(valid_w[0]), 32'h0);
        check("t6 reset parity_err", 32'(perr_w[0]),  32'h0);
        check("t6 reset frame_err",  32'(ferr_w[0]),  32'h0);
        check("t6 reset overrun",    32'(ovr_w[0]),   32'h0);
        check("t6 reset busy",       32'(busy_w[0]),  32'h0);
      end
    join
    rx_w[0] = 1'b1;
    idle(4);
    reset = 1'b1;
    idle(4);
    ready_w[0] = 1'b1;
    r0 = rise_cnt[0];
    send_frame(0, 8'h5A, 1'b0, 2'b11);
    idle(2 * CPB);
    check("t6 words",      32'(rise_cnt[0] - r0), 32'd1);
    check("t6 data",       32'(cap_data[0]),      32'h5A);
    check("t6 parity_err", 32'(cap_perr[0]),      32'h0);
    check("t6 frame_err",  32'(cap_ferr[0]),      32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
